// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises NUM_SRC request lines, latches rising edges into a
// pending register gated by a mask, and drives one level request to the CPU. INTC_AUTO_ACK_EN adds read-acknowledge.
module int_ctrl #(
    parameter int          NUM_SRC  = 8,
    parameter logic [7:0]  MASK_ID  = 8'hF0,
    parameter logic [7:0]  PEND_ID  = 8'hF1,
    parameter logic [7:0]  IDX_ID   = 8'hF2,
    parameter logic [7:0]  MASK_RST = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               io_strb,
`ifdef INTC_AUTO_ACK_EN
    input  logic               io_rd_strb,
`endif
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    output logic               irq_out
);

    localparam logic [NUM_SRC-1:0] MASK_RST_V = MASK_RST[NUM_SRC-1:0];

    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_hist;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_mask;
    logic               r_irq;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_act;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_ack_vec;
    logic               w_any;
    logic [2:0]         w_idx;
    logic               w_wr_mask;
    logic               w_wr_pend;

    assign w_edge    = r_sync2 & ~r_hist;
    assign w_act     = r_pend & r_mask;
    assign w_any     = |w_act;
    assign w_wr_mask = io_strb && (port_id == MASK_ID);
    assign w_wr_pend = io_strb && (port_id == PEND_ID);

    // Source 0 has highest priority: scan downward so the lowest set bit wins.
    always_comb begin
        w_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_idx = 3'(i);
            end
        end
    end

`ifdef INTC_AUTO_ACK_EN
    logic w_ack;
    assign w_ack = io_rd_strb && (port_id == IDX_ID) && w_any;
    always_comb begin
        w_ack_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_vec[i] = w_ack && (w_idx == 3'(i));
        end
    end
`else
    assign w_ack_vec = '0;
`endif

    assign w_clr = (w_wr_pend ? out_port[NUM_SRC-1:0] : '0) | w_ack_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= src_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Edge is OR-ed in after the clear so a simultaneous set always survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= MASK_RST_V;
        end else if (w_wr_mask) begin
            r_mask <= out_port[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_any;
        end
    end

    assign irq_out = r_irq;

    always_comb begin
        rd_data = 8'h00;
        rd_hit  = 1'b0;
        if (port_id == MASK_ID) begin
            rd_data = 8'(r_mask);
            rd_hit  = 1'b1;
        end else if (port_id == PEND_ID) begin
            rd_data = 8'(r_pend);
            rd_hit  = 1'b1;
        end else if (port_id == IDX_ID) begin
            rd_data = {w_any, 4'b0000, w_idx};
            rd_hit  = 1'b1;
        end
    end

endmodule
